// File: rtl/clk_div_prog.sv
// clk_div_prog
//   Programmable integer clock divider with 50% duty cycle for both even and
//   odd ratios. Odd ratios use a negedge copy of the posedge phase to obtain
//   half-cycle resolution. A new ratio is accepted through a valid/ready
//   handshake and is applied only at a period boundary, so there are no runt
//   pulses. The enable input is sampled at period boundaries only. When the
//   enable is low at a boundary, the divider parks with its output low.
//
// Ports
//   clk        in   source clock
//   rst        in   asynchronous, active-high reset
//   en         in   run enable, sampled at period boundaries
//   cfg_valid  in   a new divide ratio is offered
//   cfg_div    in   offered divide ratio N (W bits, legal values >= 2)
//   cfg_ready  out  high when no ratio is pending
//   cfg_err    out  one-cycle pulse when an offered ratio is illegal (0 or 1)
//   clk_out    out  divided clock
//   tick       out  one-cycle pulse in the clk cycle where a period starts
//   cur_div    out  divide ratio currently in effect

module clk_div_prog #(
    parameter int unsigned W       = 8,
    parameter int unsigned DIV_RST = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_div,
    output logic         cfg_ready,
    output logic         cfg_err,
    output logic         clk_out,
    output logic         tick,
    output logic [W-1:0] cur_div
);

    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] DIV_INIT = W'(DIV_RST);
    localparam logic [W-1:0] CNT_INIT = W'(DIV_RST - 1);
    localparam logic [W-1:0] H_INIT   = W'((DIV_RST + 1) / 2);

    // Ratio in effect, its high-phase length H = ceil(N/2), and the pending ratio
    logic [W-1:0] n_div;
    logic [W-1:0] h_div;
    logic [W-1:0] pend_div;

    logic [W-1:0] cnt;
    logic         p_q;
    logic         n_q;

    // Next-state terms
    logic         boundary;
    logic         apply;
    logic         accept;
    logic         legal;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] n_nxt;
    logic [W-1:0] h_nxt;
    logic [W-1:0] cnt_nxt;
    logic         p_nxt;

    always_comb begin
        // While parked, cnt is held at N-1, so every edge is a boundary.
        boundary = (cnt == (n_div - ONE));
        // cfg_ready low means a ratio is pending. A ratio accepted on this edge
        // is not yet pending, so it waits for the following boundary.
        apply    = boundary && !cfg_ready;
        accept   = cfg_valid && cfg_ready;
        legal    = (cfg_div > ONE);
        cnt_inc  = cnt + ONE;

        n_nxt    = apply ? pend_div : n_div;
        // ceil(N/2) without needing an extra bit: N>>1 plus the odd bit
        h_nxt    = (n_nxt >> 1) + {{(W-1){1'b0}}, n_nxt[0]};

        if (boundary) begin
            if (en) begin
                cnt_nxt = '0;
                p_nxt   = 1'b1;
            end else begin
                // Park at N-1 of the (possibly new) ratio.
                cnt_nxt = n_nxt - ONE;
                p_nxt   = 1'b0;
            end
        end else begin
            cnt_nxt = cnt_inc;
            p_nxt   = (cnt_inc < h_div);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_div     <= DIV_INIT;
            h_div     <= H_INIT;
            pend_div  <= '0;
            cnt       <= CNT_INIT;
            p_q       <= 1'b0;
            tick      <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            n_div   <= n_nxt;
            h_div   <= h_nxt;
            cnt     <= cnt_nxt;
            p_q     <= p_nxt;
            // cnt only reaches 0 when a period starts; a parked cnt is N-1 >= 1.
            tick    <= (cnt_nxt == '0);
            cfg_err <= accept && !legal;

            if (apply) begin
                cfg_ready <= 1'b1;
            end else if (accept && legal) begin
                pend_div  <= cfg_div;
                cfg_ready <= 1'b0;
            end
        end
    end

    // Half-cycle delayed copy of the posedge phase, used for odd ratios
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            n_q <= 1'b0;
        end else begin
            n_q <= p_q;
        end
    end

    // Odd N: the AND trims half a cycle from the front of the high phase.
    // p_q and n_q change on opposite edges, so the AND never sees both inputs
    // move at once. The select changes only at a boundary edge. Just before
    // that edge, p_q and n_q are both low, so both mux inputs are low at the
    // switch.
    assign clk_out = n_div[0] ? (p_q & n_q) : p_q;
    assign cur_div = n_div;

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

    localparam int unsigned W       = 8;
    localparam int unsigned DIV_RST = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         cfg_valid;
    logic [W-1:0] cfg_div;
    logic         cfg_ready;
    logic         cfg_err;
    logic         clk_out;
    logic         tick;
    logic [W-1:0] cur_div;

    clk_div_prog #(.W(W), .DIV_RST(DIV_RST)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_div   (cur_div)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model at the period level: ratio, position within period,
    // parked flag and handshake state.
    int  m_n;
    int  m_phase;
    bit  m_parked;
    bit  m_pend_v;
    int  m_pend;
    bit  m_ready;
    bit  m_err;

    task automatic model_reset();
        m_n      = DIV_RST;
        m_phase  = DIV_RST - 1;
        m_parked = 1'b0;
        m_pend_v = 1'b0;
        m_pend   = 0;
        m_ready  = 1'b1;
        m_err    = 1'b0;
    endtask

    // Expected clk_out in half-cycle 'half' (0 = after posedge, 1 = after negedge).
    // Each period is 2N halves, and exactly N of them are high. Even N is high
    // in halves 0..N-1. Odd N is high in halves 1..N.
    function automatic bit exp_out(input int half);
        int h;
        if (m_parked) return 1'b0;
        h = 2 * m_phase + half;
        if (m_n % 2 == 0) return (h < m_n);
        return (h >= 1) && (h <= m_n);
    endfunction

    task automatic model_edge();
        bit acc;
        bit bnd;
        acc   = cfg_valid && m_ready;
        bnd   = m_parked || (m_phase == m_n - 1);
        m_err = acc && (int'(cfg_div) < 2);
        if (bnd) begin
            if (m_pend_v) begin
                m_n      = m_pend;
                m_pend_v = 1'b0;
                m_ready  = 1'b1;
            end
            if (en) begin
                m_parked = 1'b0;
                m_phase  = 0;
            end else begin
                m_parked = 1'b1;
            end
        end else begin
            m_phase++;
        end
        if (acc && int'(cfg_div) >= 2) begin
            m_pend   = int'(cfg_div);
            m_pend_v = 1'b1;
            m_ready  = 1'b0;
        end
    endtask

    // One clk cycle: update the model at the posedge, then check the outputs
    // in both halves of the cycle. Returns at negedge+1, when inputs may change.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, "/out_p"},  32'(clk_out),   32'(exp_out(0)));
        check({tag, "/tick"},   32'(tick),      32'(!m_parked && m_phase == 0));
        check({tag, "/cur"},    32'(cur_div),   32'(m_n));
        check({tag, "/ready"},  32'(cfg_ready), 32'(m_ready));
        check({tag, "/err"},    32'(cfg_err),   32'(m_err));
        @(negedge clk);
        #1;
        check({tag, "/out_n"},  32'(clk_out),   32'(exp_out(1)));
    endtask

    task automatic offer(input int unsigned div);
        cfg_valid = 1'b1;
        cfg_div   = W'(div);
        cycle("offer");
        cfg_valid = 1'b0;
    endtask

    initial begin
        bit ok;
        int unsigned r;

        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        model_reset();
        #1;
        check("rst/out",   32'(clk_out),   32'd0);
        check("rst/tick",  32'(tick),      32'd0);
        check("rst/cur",   32'(cur_div),   32'(DIV_RST));
        check("rst/ready", 32'(cfg_ready), 32'd1);
        check("rst/err",   32'(cfg_err),   32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;

        // Default ratio 3
        repeat (9) cycle("div3");

        // Ratio 4 offered mid-period
        cycle("div3b");
        offer(4);
        repeat (12) cycle("div4");

        // Illegal ratios
        offer(1);
        cycle("ill1");
        offer(0);
        repeat (3) cycle("ill0");

        // Ratio 5, then drop en at cnt=1
        offer(5);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle("to5");
            if (m_n == 5 && !m_parked && m_phase == 1) begin
                ok = 1'b1;
                break;
            end
        end
        check("wait_cnt1", 32'(ok), 32'd1);
        en = 1'b0;
        repeat (10) cycle("park");
        en = 1'b1;
        repeat (7) cycle("resume");

        // Ratio 255: wrap from 254 to 0
        offer(255);
        repeat (530) cycle("div255");

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            en        = ($urandom_range(0, 9) != 0);
            cfg_valid = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 9);
            case (r)
                0:       cfg_div = W'(0);
                1:       cfg_div = W'(1);
                2:       cfg_div = W'(255);
                3:       cfg_div = W'(254);
                default: cfg_div = W'($urandom_range(2, 9));
            endcase
            cycle("rand");
        end
        cfg_valid = 1'b0;
        en        = 1'b1;

        // Reset while clk_out is high and a ratio is pending
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            if (m_ready && m_n != 6) begin
                cfg_valid = 1'b1;
                cfg_div   = W'(6);
            end else begin
                cfg_valid = 1'b0;
            end
            cycle("to6");
            if (m_n == 6 && m_ready && !m_parked && m_phase == 0) begin
                ok = 1'b1;
                break;
            end
        end
        cfg_valid = 1'b0;
        check("wait_div6", 32'(ok), 32'd1);
        offer(9);
        check("rst_pre_pend", 32'(cfg_ready), 32'd0);
        check("rst_pre_high", 32'(clk_out),   32'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_mid/out",   32'(clk_out),   32'd0);
        check("rst_mid/cur",   32'(cur_div),   32'(DIV_RST));
        check("rst_mid/ready", 32'(cfg_ready), 32'd1);
        check("rst_mid/tick",  32'(tick),      32'd0);
        #1;
        rst = 1'b0;
        repeat (10) cycle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
